// File: rtl/wr_arb_ctrl.sv
// Write-side controller for the async FIFO: round-robin arbitration of NREQ requesters onto one write port,
// write pointer (binary/Gray), registered full flag. Optional almost_full via `WR_ARB_ALMOST_FULL_EN.
module wr_arb_ctrl #(
   parameter int SIZE      = 4,
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int AF_MARGIN = 2
) (
   input  logic               wr_clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    gnt,
   input  logic [SIZE:0]      rq_ptr_gray_sync,
   output logic               wr_en,
   output logic [SIZE-1:0]    wr_addr,
   output logic [DW-1:0]      wr_data,
   output logic [SIZE:0]      wr_ptr_gray,
   output logic               full,
   output logic               almost_full
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [SIZE:0]   wbin_q, wbin_d;
   logic [SIZE:0]   wgray_q, wgray_d;
   logic [LW-1:0]   last_q, last_d;
   logic            wr_en_q, wr_en_d;
   logic [SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;
   logic            full_q, full_d;
   logic            af_q, af_d;

   logic            accept;
   logic [LW-1:0]   gnt_idx;
   int              idx;

   // Circular scan starting just after the last winner; gated by reset and by full.
   always_comb begin
      gnt     = '0;
      accept  = 1'b0;
      gnt_idx = last_q;
      idx     = 0;
      if (rst_n && !full_q) begin
         for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_q) + i) % NREQ;
            if (!accept && req[idx]) begin
               accept  = 1'b1;
               gnt_idx = LW'(idx);
            end
         end
      end
      if (accept) gnt[gnt_idx] = 1'b1;
   end

   always_comb begin
      wbin_d    = wbin_q + {{SIZE{1'b0}}, accept};
      wgray_d   = wbin_d ^ (wbin_d >> 1);
      last_d    = accept ? gnt_idx : last_q;
      wr_en_d   = accept;
      wr_addr_d = accept ? wbin_q[SIZE-1:0] : wr_addr_q;
      wr_data_d = accept ? req_data[gnt_idx*DW +: DW] : wr_data_q;
      // Full when the next write pointer laps the read pointer by exactly one FIFO depth.
      full_d    = (wgray_d == {~rq_ptr_gray_sync[SIZE:SIZE-1], rq_ptr_gray_sync[SIZE-2:0]});
   end

`ifdef WR_ARB_ALMOST_FULL_EN
   logic [SIZE:0]   rbin;
   logic [SIZE:0]   used;
   logic [SIZE+1:0] free_slots;

   always_comb begin
      rbin = '0;
      for (int i = 0; i <= SIZE; i++) rbin[i] = ^(rq_ptr_gray_sync >> i);
      used       = wbin_d - rbin;
      free_slots = (SIZE+2)'(1 << SIZE) - {1'b0, used};
      af_d       = (int'(free_slots) <= AF_MARGIN);
   end
`else
   always_comb af_d = 1'b0;
`endif

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin_q    <= '0;
         wgray_q   <= '0;
         last_q    <= LW'(NREQ - 1);
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         full_q    <= 1'b0;
         af_q      <= 1'b0;
      end else begin
         wbin_q    <= wbin_d;
         wgray_q   <= wgray_d;
         last_q    <= last_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         full_q    <= full_d;
         af_q      <= af_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign wr_ptr_gray = wgray_q;
   assign full        = full_q;
   assign almost_full = af_q;

endmodule

// File: tb/tb_wr_arb_ctrl.sv
// Directed bench for wr_arb_ctrl: driver pushes expected memory writes, a monitor pops them on wr_en.
module tb_wr_arb_ctrl;

  logic        wr_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [4:0]  rq_ptr_gray_sync;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  wr_ptr_gray;
  logic        full;
  logic        almost_full;

  int total = 0;
  int bad = 0;
  logic [16:0] exp_q[$];
  logic [4:0]  exp_wbin;
  logic [4:0]  rbin;

  always #5 wr_clk = ~wr_clk;

  wr_arb_ctrl #(.SIZE(4), .NREQ(4), .DW(8), .AF_MARGIN(2)) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .rq_ptr_gray_sync(rq_ptr_gray_sync), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ptr_gray(wr_ptr_gray), .full(full), .almost_full(almost_full)
  );

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: check the combinational grant, record the write it implies, advance past the edge.
  task automatic cycle(input logic [3:0] eg);
    int k;
    logic [7:0] d;
    @(negedge wr_clk);
    check("gnt", {28'd0, gnt}, {28'd0, eg});
    if (eg != 4'd0) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (eg[i]) k = i;
      d = req_data[k*8 +: 8];
      exp_q.push_back({exp_wbin[3:0], d, g5(exp_wbin + 5'd1)});
      exp_wbin = exp_wbin + 5'd1;
    end
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'd0;
    rq_ptr_gray_sync = 5'd0;
    rbin = 5'd0;
    exp_q.delete();
    exp_wbin = 5'd0;
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() != 0) begin
        @(posedge wr_clk);
        #1;
      end
    end
    @(negedge wr_clk);
    check("drain", exp_q.size(), 0);
    @(posedge wr_clk);
    #1;
  endtask

  // Monitor: every presented write must match the oldest expected one.
  always @(negedge wr_clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {15'd0, wr_addr, wr_data, wr_ptr_gray}, 32'hFFFF_FFFF);
      end else begin
        check("write", {15'd0, wr_addr, wr_data, wr_ptr_gray}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req = 4'b1111;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    rq_ptr_gray_sync = 5'd0;
    rbin = 5'd0;
    exp_wbin = 5'd0;
    #2;
    check("rst_gnt", {28'd0, gnt}, 0);
    check("rst_outs", {20'd0, wr_en, wr_addr, wr_ptr_gray, full, almost_full}, 0);
    check("rst_data", {24'd0, wr_data}, 0);
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;

    // Round robin with all requesters active
    cycle(4'b0001);
    cycle(4'b0010);
    cycle(4'b0100);
    cycle(4'b1000);
    cycle(4'b0001);
    cycle(4'b0010);
    cycle(4'b0100);
    check("inflight_wr_en", {31'd0, wr_en}, 1);
    // Reset while a write is in flight
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {20'd0, wr_en, wr_addr, wr_ptr_gray, full, almost_full}, 0);
    check("midrst_gnt", {28'd0, gnt}, 0);
    exp_q.delete();
    exp_wbin = 5'd0;
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;
    cycle(4'b0001);
    cycle(4'b0010);
    drain();

    // Fill to full with a single requester
    do_reset();
    req = 4'b0100;
    for (int k = 1; k <= 16; k++) begin
      req_data[23:16] = 8'(8'h80 + k);
      cycle(4'b0100);
      check("fill_full", {31'd0, full}, (k == 16) ? 1 : 0);
`ifdef WR_ARB_ALMOST_FULL_EN
      check("fill_af", {31'd0, almost_full}, (k >= 14) ? 1 : 0);
`else
      check("fill_af", {31'd0, almost_full}, 0);
`endif
    end
    check("full_gray", {27'd0, wr_ptr_gray}, 32'b11000);
    cycle(4'b0000);
    // One read slot freed
    rq_ptr_gray_sync = 5'b00001;
    cycle(4'b0000);
    check("release_full", {31'd0, full}, 0);
    cycle(4'b0100);
    check("refull", {31'd0, full}, 1);
    cycle(4'b0000);
    drain();

    // Wrap-around with the reader keeping pace
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 40; i++) begin
      req_data[15:8] = 8'(i);
      cycle(4'b0010);
      check("wrap_nofull", {31'd0, full}, 0);
      if (i == 30) check("gray_31", {27'd0, wr_ptr_gray}, 32'b10000);
      if (i == 31) check("gray_32", {27'd0, wr_ptr_gray}, 32'b00000);
      rbin = rbin + 5'd1;
      rq_ptr_gray_sync = g5(rbin);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
